// File: rtl/gcn_pkg.sv
// Shared definitions for the row streaming / argmax datapath.
//   DEF_ADJ_DOT_PROD_WIDTH : default width of one dot-product element
//   DEF_DOT_PROD_COLS      : default number of elements per row
//   DEF_ARGMAX_WIDTH       : default width of an argmax index
//   stream_state_t         : row streamer FSM state encoding
package gcn_pkg;

    localparam int DEF_ADJ_DOT_PROD_WIDTH = 16;
    localparam int DEF_DOT_PROD_COLS      = 3;
    localparam int DEF_ARGMAX_WIDTH       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } stream_state_t;

endpackage

// File: rtl/row_addr_counter.sv
// Row address counter for the row streamer.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous load of zero (has priority over enable)
//   enable     : advance by one row; holds at NUM_ROWS-1 (never wraps)
//   count      : current row index
//   last       : count is at NUM_ROWS-1
module row_addr_counter #(
    parameter int NUM_ROWS       = 6,
    parameter int ROW_ADDR_WIDTH = $clog2(NUM_ROWS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      enable,
    output logic [ROW_ADDR_WIDTH-1:0] count,
    output logic                      last
);

    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_IDX = ROW_ADDR_WIDTH'(NUM_ROWS - 1);

    assign last = (count == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/row_argmax_streamer.sv
// Streams NUM_ROWS rows out of a row memory into an external argmax unit and
// collects one argmax index per row.
//
// State table:
//   IDLE  | waiting for start; start is only accepted here
//   ISSUE | one row read per cycle, addresses 0..NUM_ROWS-1
//   DRAIN | reads finished, waiting for the last argmax to be captured
//   DONE  | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   start        : one-cycle request to stream all rows
//   row_rd_en    : row memory read strobe
//   row_rd_addr  : row index being read
//   row_rd_data  : row data, valid one cycle after row_rd_en
//   is_read_row  : cur_row holds a valid row for the argmax unit
//   cur_row      : row presented with is_read_row (holds when not loaded)
//   r_row        : cur_row delayed by one cycle
//   argmax_in    : argmax result, valid one cycle after is_read_row
//   busy         : pass in progress (ISSUE/DRAIN)
//   done         : one-cycle pulse after the last result is captured
//   result       : per-row argmax buffer
//
// Build option: ROW_STREAM_RESULT_BUF_EN enables the result buffer. Without it
// result is tied to zero and argmax_in is ignored; pass timing is identical.
module row_argmax_streamer
    import gcn_pkg::*;
#(
    parameter int ADJ_DOT_PROD_WIDTH = DEF_ADJ_DOT_PROD_WIDTH,
    parameter int DOT_PROD_COLS      = DEF_DOT_PROD_COLS,
    parameter int NUM_ROWS           = 6,
    parameter int ROW_ADDR_WIDTH     = $clog2(NUM_ROWS),
    parameter int ARGMAX_WIDTH       = DEF_ARGMAX_WIDTH
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                start,
    output logic                                                row_rd_en,
    output logic [ROW_ADDR_WIDTH-1:0]                           row_rd_addr,
    input  logic [DOT_PROD_COLS-1:0][ADJ_DOT_PROD_WIDTH-1:0]    row_rd_data,
    output logic                                                is_read_row,
    output logic [DOT_PROD_COLS-1:0][ADJ_DOT_PROD_WIDTH-1:0]    cur_row,
    output logic [DOT_PROD_COLS-1:0][ADJ_DOT_PROD_WIDTH-1:0]    r_row,
    input  logic [ARGMAX_WIDTH-1:0]                             argmax_in,
    output logic                                                busy,
    output logic                                                done,
    output logic [NUM_ROWS-1:0][ARGMAX_WIDTH-1:0]               result
);

    stream_state_t state, state_nxt;

    logic                      cnt_clear;
    logic                      cnt_en;
    logic                      cnt_last;
    logic [ROW_ADDR_WIDTH-1:0] cnt;

    // Pipeline valids and "last row" markers: read -> data -> cur_row -> capture
    logic rd_valid;
    logic rd_last;
    logic cur_last;
    logic cap_last;

    row_addr_counter #(
        .NUM_ROWS       (NUM_ROWS),
        .ROW_ADDR_WIDTH (ROW_ADDR_WIDTH)
    ) u_row_addr_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cnt),
        .last   (cnt_last)
    );

    assign row_rd_addr = cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        row_rd_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    cnt_clear = 1'b1;
                end
            end
            ISSUE: begin
                row_rd_en = 1'b1;
                busy      = 1'b1;
                cnt_en    = 1'b1;
                if (cnt_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (cap_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            is_read_row <= 1'b0;
            cur_last    <= 1'b0;
            cap_last    <= 1'b0;
            cur_row     <= '0;
            r_row       <= '0;
        end else begin
            rd_valid    <= row_rd_en;
            rd_last     <= row_rd_en && cnt_last;
            is_read_row <= rd_valid;
            cur_last    <= rd_last;
            cap_last    <= cur_last;
            if (rd_valid) begin
                cur_row <= row_rd_data;
            end
            r_row <= cur_row;
        end
    end

`ifdef ROW_STREAM_RESULT_BUF_EN
    // Row index travels alongside the data so each argmax lands in its own slot.
    logic                                  cap_valid;
    logic [ROW_ADDR_WIDTH-1:0]             rd_idx;
    logic [ROW_ADDR_WIDTH-1:0]             cur_idx;
    logic [ROW_ADDR_WIDTH-1:0]             cap_idx;
    logic [NUM_ROWS-1:0][ARGMAX_WIDTH-1:0] result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_valid <= 1'b0;
            rd_idx    <= '0;
            cur_idx   <= '0;
            cap_idx   <= '0;
            result_q  <= '0;
        end else begin
            cap_valid <= is_read_row;
            rd_idx    <= cnt;
            cur_idx   <= rd_idx;
            cap_idx   <= cur_idx;
            if (cap_valid) begin
                result_q[cap_idx] <= argmax_in;
            end
        end
    end

    assign result = result_q;
`else
    logic unused_argmax;
    assign unused_argmax = ^argmax_in;
    assign result        = '0;
`endif

endmodule
